// File: rtl/wb_commit_arbiter_pkg.sv
// Shared definitions for the writeback commit arbiter: register-file geometry
// and small sizing/decoding helpers.
package wb_commit_arbiter_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // One-hot of a destination register; $0 never produces a bit.
    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_AW-1:0] a);
        return (a == ZERO_REG) ? '0 : (NUM_REGS'(1) << a);
    endfunction

endpackage

// File: rtl/wb_commit_arbiter_if.sv
// Producer-side request bundle and GRF write-port bundle of the commit arbiter.
interface wb_commit_arbiter_if #(
    parameter int NUM_SRC = 2,
    parameter int DW      = 32
) ();
    import wb_commit_arbiter_pkg::*;

    logic                       flush;
    logic [NUM_SRC-1:0]         in_valid;
    logic [NUM_SRC-1:0]         in_ready;
    logic [NUM_SRC*REG_AW-1:0]  in_addr;
    logic [NUM_SRC*DW-1:0]      in_data;
    logic [NUM_SRC*32-1:0]      in_pc;
    logic                       rf_we;
    logic [REG_AW-1:0]          rf_addr;
    logic [DW-1:0]              rf_wdata;
    logic [31:0]                rf_pc;
    logic [NUM_REGS-1:0]        pending;

    modport master (
        output flush, in_valid, in_addr, in_data, in_pc,
        input  in_ready, rf_we, rf_addr, rf_wdata, rf_pc, pending
    );

    modport slave (
        input  flush, in_valid, in_addr, in_data, in_pc,
        output in_ready, rf_we, rf_addr, rf_wdata, rf_pc, pending
    );

endinterface

// File: rtl/wb_commit_arbiter_fifo.sv
// One-channel synchronous FIFO with flush, combinational head and a mask of
// destination registers currently held in valid slots.
module wb_commit_arbiter_fifo
    import wb_commit_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [REG_AW-1:0]   wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic [31:0]         wr_pc,
    output logic                full,
    output logic                empty,
    output logic [REG_AW-1:0]   head_addr,
    output logic [DW-1:0]       head_data,
    output logic [31:0]         head_pc,
    output logic [NUM_REGS-1:0] pend_mask
);
    localparam int AW = clog2(DEPTH);

    logic [REG_AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0]     data_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];

    // Extra wrap bit distinguishes full from empty when the indices match.
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] count;
    logic [NUM_REGS-1:0] slot_mask [DEPTH];

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign head_addr = addr_mem[rd_ptr_reg[AW-1:0]];
    assign head_data = data_mem[rd_ptr_reg[AW-1:0]];
    assign head_pc   = pc_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop  && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            addr_mem[wr_ptr_reg[AW-1:0]] <= wr_addr;
            data_mem[wr_ptr_reg[AW-1:0]] <= wr_data;
            pc_mem[wr_ptr_reg[AW-1:0]]   <= wr_pc;
        end
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [AW-1:0] offs;
            assign offs = AW'(gi) - rd_ptr_reg[AW-1:0];
            assign slot_mask[gi] = ({1'b0, offs} < count) ? reg_bit(addr_mem[gi]) : '0;
        end
    endgenerate

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) pend_mask = pend_mask | slot_mask[i];
    end

endmodule

// File: rtl/wb_commit_arbiter.sv
// Writeback commit arbiter: per-producer FIFOs, round-robin grant onto one
// registered GRF write port, and the live pending-register mask.
module wb_commit_arbiter
    import wb_commit_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int DW      = 32
) (
    input  logic              clk,
    input  logic              reset,
    wb_commit_arbiter_if.slave bus
);
    localparam int GW = (NUM_SRC > 1) ? clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]  full, empty, grant_vec;
    logic [REG_AW-1:0]   head_addr [NUM_SRC];
    logic [DW-1:0]       head_data [NUM_SRC];
    logic [31:0]         head_pc   [NUM_SRC];
    logic [NUM_REGS-1:0] pend_mask [NUM_SRC];

    logic [GW-1:0]       rr_reg, rr_next, grant_idx;
    logic                grant_found;
    logic                rf_we_reg;
    logic [REG_AW-1:0]   rf_addr_reg;
    logic [DW-1:0]       rf_wdata_reg;
    logic [31:0]         rf_pc_reg;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_chan
            wb_commit_arbiter_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .flush     (bus.flush),
                .push      (bus.in_valid[gi] & ~full[gi]),
                .pop       (grant_vec[gi]),
                .wr_addr   (bus.in_addr[REG_AW*gi +: REG_AW]),
                .wr_data   (bus.in_data[DW*gi +: DW]),
                .wr_pc     (bus.in_pc[32*gi +: 32]),
                .full      (full[gi]),
                .empty     (empty[gi]),
                .head_addr (head_addr[gi]),
                .head_data (head_data[gi]),
                .head_pc   (head_pc[gi]),
                .pend_mask (pend_mask[gi])
            );
        end
    endgenerate

    assign bus.in_ready = ~full;

    // First non-empty channel at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_reg) + k) % NUM_SRC;
            if (!grant_found && !empty[idx]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(idx);
            end
        end
        if (grant_found) grant_vec[grant_idx] = 1'b1;
        rr_next = (grant_idx == GW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_reg       <= '0;
            rf_we_reg    <= 1'b0;
            rf_addr_reg  <= '0;
            rf_wdata_reg <= '0;
            rf_pc_reg    <= '0;
        end else if (grant_found) begin
            rr_reg    <= rr_next;
            rf_pc_reg <= head_pc[grant_idx];
            // A $0 result still uses its commit slot but never writes the GRF.
            if (head_addr[grant_idx] == ZERO_REG) begin
                rf_we_reg    <= 1'b0;
                rf_addr_reg  <= ZERO_REG;
                rf_wdata_reg <= '0;
            end else begin
                rf_we_reg    <= 1'b1;
                rf_addr_reg  <= head_addr[grant_idx];
                rf_wdata_reg <= head_data[grant_idx];
            end
        end else begin
            rf_we_reg <= 1'b0;
        end
    end

    always_comb begin
        bus.pending = rf_we_reg ? reg_bit(rf_addr_reg) : '0;
        for (int i = 0; i < NUM_SRC; i++) bus.pending = bus.pending | pend_mask[i];
    end

    assign bus.rf_we    = rf_we_reg;
    assign bus.rf_addr  = rf_addr_reg;
    assign bus.rf_wdata = rf_wdata_reg;
    assign bus.rf_pc    = rf_pc_reg;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Bench for wb_commit_arbiter: directed scenarios then random traffic, checked
// each cycle against a queue-based reference model.
module tb_wb_commit_arbiter;
    localparam int NS    = 2;
    localparam int DEPTH = 2;
    localparam int DW    = 32;

    typedef struct {
        logic [4:0]    addr;
        logic [DW-1:0] data;
        logic [31:0]   pc;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_commit_arbiter_if #(.NUM_SRC(NS), .DW(DW)) bus ();

    wb_commit_arbiter #(.NUM_SRC(NS), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ent_t          mq [NS][$];
    int            m_rr;
    logic          m_we;
    logic [4:0]    m_addr;
    logic [DW-1:0] m_wdata;
    logic [31:0]   m_pc;

    int errors = 0;
    int checks = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < NS; i++)
            foreach (mq[i][j]) if (mq[i][j].addr != 5'd0) m[mq[i][j].addr] = 1'b1;
        if (m_we) m[m_addr] = 1'b1;
        return m;
    endfunction

    task automatic model_edge(logic rst, logic fl, logic [NS-1:0] v,
                              logic [NS*5-1:0] a, logic [NS*DW-1:0] d, logic [NS*32-1:0] p);
        bit   rdy [NS];
        int   g;
        ent_t e;
        if (rst) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_rr = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_pc = '0;
            return;
        end
        for (int i = 0; i < NS; i++) rdy[i] = (mq[i].size() < DEPTH);
        g = -1;
        for (int k = 0; k < NS; k++)
            if (g < 0 && mq[(m_rr + k) % NS].size() > 0) g = (m_rr + k) % NS;
        if (g >= 0) begin
            e       = mq[g].pop_front();
            m_we    = (e.addr != 5'd0);
            m_addr  = m_we ? e.addr : 5'd0;
            m_wdata = m_we ? e.data : '0;
            m_pc    = e.pc;
            m_rr    = (g + 1) % NS;
            $display("commit ch%0d addr=%0d data=%h pc=%h we=%0d", g, e.addr, e.data, e.pc, m_we);
        end else begin
            m_we = 1'b0;
        end
        if (fl) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < NS; i++)
                if (v[i] && rdy[i]) mq[i].push_back('{a[5*i +: 5], d[DW*i +: DW], p[32*i +: 32]});
        end
    endtask

    task automatic check_all();
        logic [NS-1:0] er;
        for (int i = 0; i < NS; i++) er[i] = (mq[i].size() < DEPTH);
        check("in_ready", 64'(bus.in_ready), 64'(er));
        check("rf_we",    64'(bus.rf_we),    64'(m_we));
        check("rf_addr",  64'(bus.rf_addr),  64'(m_addr));
        check("rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
        check("rf_pc",    64'(bus.rf_pc),    64'(m_pc));
        check("pending",  64'(bus.pending),  64'(model_pending()));
    endtask

    task automatic cycle(logic rst, logic fl, logic [NS-1:0] v,
                         logic [NS*5-1:0] a, logic [NS*DW-1:0] d, logic [NS*32-1:0] p);
        reset        = rst;
        bus.flush    = fl;
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.in_pc    = p;
        @(posedge clk);
        model_edge(rst, fl, v, a, d, p);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [NS*5-1:0]  a;
        logic [NS*DW-1:0] d;
        logic [NS*32-1:0] p;
        reset = 1'b1; bus.flush = 1'b0; bus.in_valid = '0;
        bus.in_addr = '0; bus.in_data = '0; bus.in_pc = '0;
        m_rr = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_pc = '0;

        // Reset with all requests asserted
        cycle(1'b1, 1'b0, 2'b11, {5'd7, 5'd6}, {32'h77, 32'h66}, {32'h4, 32'h8});
        cycle(1'b1, 1'b0, 2'b11, {5'd7, 5'd6}, {32'h77, 32'h66}, {32'h4, 32'h8});
        idle(1);
        check("rst_pending", 64'(bus.pending), 64'h0);
        check("rst_ready",   64'(bus.in_ready), 64'h3);

        // Single push on ch0
        cycle(1'b0, 1'b0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h1234}, {32'h0, 32'h100});
        check("single_pend_q", 64'(bus.pending[5]), 64'h1);
        idle(1);
        check("single_we",   64'(bus.rf_we),    64'h1);
        check("single_addr", 64'(bus.rf_addr),  64'h5);
        check("single_data", 64'(bus.rf_wdata), 64'h1234);
        check("single_pend_rf", 64'(bus.pending[5]), 64'h1);
        idle(1);
        check("single_pend_clr", 64'(bus.pending), 64'h0);

        // Contention: both channels every cycle
        for (int c = 0; c < 6; c++) begin
            a = {5'(9 + c), 5'(1 + c)};
            d = {32'(32'hB00 + c), 32'(32'hA00 + c)};
            p = {32'(32'h2000 + 4 * c), 32'(32'h1000 + 4 * c)};
            cycle(1'b0, 1'b0, 2'b11, a, d, p);
        end
        idle(6);

        // $0 on ch1
        cycle(1'b0, 1'b0, 2'b10, {5'd0, 5'd0}, {32'hFFFF, 32'h0}, {32'h300, 32'h0});
        idle(1);
        check("zero_we",   64'(bus.rf_we),   64'h0);
        check("zero_pend", 64'(bus.pending), 64'h0);
        idle(2);

        // Flush: steer RR to ch1 first so $3 is the head granted at the flush edge
        cycle(1'b0, 1'b0, 2'b01, {5'd0, 5'd2}, {32'h0, 32'h22}, {32'h0, 32'h400});
        idle(2);
        cycle(1'b0, 1'b0, 2'b11, {5'd10, 5'd3}, {32'h1010, 32'h33}, {32'h504, 32'h500});
        cycle(1'b0, 1'b0, 2'b11, {5'd11, 5'd4}, {32'h1111, 32'h44}, {32'h50c, 32'h508});
        cycle(1'b0, 1'b1, 2'b10, {5'd7,  5'd0}, {32'h7777, 32'h0},  {32'h510, 32'h0});
        check("flush_commit", 64'(bus.rf_addr), 64'h3);
        idle(3);
        check("flush_pend", 64'(bus.pending), 64'h0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            a = 10'($urandom);
            d = {$urandom, $urandom};
            p = {$urandom, $urandom};
            cycle(($urandom % 100) == 0, ($urandom % 30) == 0, 2'($urandom), a, d, p);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
